request_latch_db: RTL and testbench
===================================

Name: request_latch_db

Overview:
Next-generation elevator call-request register for all three call groups: cabin, hall-up and hall-down.
- Per button: 2-FF synchroniser, debounce counter, rising-edge press detect, set/clear latch.
- Adds optional cabin-call cancel, per-floor enable mask and registered above/here/below summaries against the current floor.
- Sits between the raw button pins and the elevator controller FSM, which clears requests as it serves floors.

Parameters:
BUTTONS_WIDTH, 8, number of floors (channels per group); must be >= 2
FLOOR_BITS, 3, width of current_floor; 2**FLOOR_BITS >= BUTTONS_WIDTH
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a level change; must be >= 1
CANCEL_EN, 1, 1 = a second cabin press on an active floor cancels it; 0 = presses only set

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_in  input  BUTTONS_WIDTH  raw cabin buttons (asynchronous, bouncy)
btn_up_out  input  BUTTONS_WIDTH  raw hall-up buttons
btn_down_out  input  BUTTONS_WIDTH  raw hall-down buttons
inactive_in_levels  input  BUTTONS_WIDTH  clear strobes for cabin requests
inactive_out_up_levels  input  BUTTONS_WIDTH  clear strobes for hall-up requests
inactive_out_down_levels  input  BUTTONS_WIDTH  clear strobes for hall-down requests
floor_enable  input  BUTTONS_WIDTH  1 = floor in service
current_floor  input  FLOOR_BITS  car position (binary)
active_in_levels  output  BUTTONS_WIDTH  latched cabin requests
active_out_up_levels  output  BUTTONS_WIDTH  latched hall-up requests
active_out_down_levels  output  BUTTONS_WIDTH  latched hall-down requests
any_active  output  1  OR of all latched requests
req_above  output  1  a request exists at a floor > current_floor
req_here  output  1  a request exists at current_floor
req_below  output  1  a request exists at a floor < current_floor

Behaviour:
Reset and clocking:
- Everything is sampled on the rising edge of clk.
- reset=1 clears all sync flops, debounced states, counters, latches and every output to 0 at the next edge. This holds mid-debounce or mid-request.
- After reset, a button already held high is treated as a new press once its debounce completes.

Synchroniser and debounce (3*BUTTONS_WIDTH independent channels):
- 2-FF synchroniser produces s.
- Counter width is clog2(DEBOUNCE_CYCLES+1).
- When s == debounced state db, the counter is held at 0.
- When s != db, the counter increments. When it reaches DEBOUNCE_CYCLES, db <= s and the counter returns to 0.
- Any glitch back to s == db before that point zeroes the counter.

Press event and latency:
- Press event = the edge at which db goes 0 -> 1.
- The latch updates on that same edge.
- Latency: the raw input is first sampled high at edge E0; the active bit is visible after edge E0+2+DEBOUNCE_CYCLES.

Latch rules per bit, in priority order:
1. floor_enable[i]=0 forces the bit to 0 and ignores presses.
2. Nonexistent buttons are always 0: active_out_up_levels[BUTTONS_WIDTH-1] and active_out_down_levels[0].
3. A press on an inactive bit sets it.
4. Cabin group with CANCEL_EN=1: a press on an already-active bit clears it.
5. Otherwise, the matching inactive_* strobe clears the bit.

Simultaneous events:
- A press and a clear strobe on the same bit in the same cycle: the press wins. The bit ends at 1, or at 0 if it was a cancel.
- A press while the bit is already active (CANCEL_EN=0 or hall groups): no change.
- Holding a button produces one press only; a new press needs db to fall and rise again.

Summaries (registered, one cycle after the latch state they reflect):
- R = active_in_levels | active_out_up_levels | active_out_down_levels.
- any_active = |R.
- req_here = R[current_floor].
- req_above = OR of R[j] for j > current_floor.
- req_below = OR of R[j] for j < current_floor.
- If current_floor >= BUTTONS_WIDTH: req_here=0, req_above=0, req_below=any_active.

Test Plan:
- Basic latch: BUTTONS_WIDTH=8, DEBOUNCE_CYCLES=4. Raise btn_in[5] cleanly at E0 -> active_in_levels=8'h20 after E0+6, not before. any_active=1 and, with current_floor=2, req_above=1 one edge later.
- Bounce: toggle btn_up_out[3] high/low every 2 cycles for 20 cycles, then hold high -> no set during bouncing; set exactly 6 edges after the first sample of the final stable high.
- Clear vs press collision: active_out_down_levels[4]=1; assert inactive_out_down_levels[4] on the same cycle a new debounced press of floor 4 completes -> bit remains 1. A lone strobe the next cycle -> bit 0.
- Cancel: CANCEL_EN=1. Press btn_in[2], release, press again -> bit set, then cleared. Repeat with CANCEL_EN=0 -> stays 1.
- Mask and illegal buttons: floor_enable[6]=0 while active_in_levels[6]=1 -> cleared next edge, and presses on 6 are ignored. btn_up_out[7] and btn_down_out[0] pressed -> outputs stay 0.
- Reset mid-operation: assert reset during a debounce count with requests latched -> all outputs 0 next edge. Keep btn_in[1] held through reset release -> set 6 edges after reset deasserts.

Source files
------------

// File: rtl/request_latch_db.sv
// Elevator call-request register: cabin, hall-up and hall-down buttons are synchronised,
// debounced and latched, and the latched requests are summarised against the car position.
module request_latch_db #(
  parameter int BUTTONS_WIDTH   = 8,
  parameter int FLOOR_BITS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit CANCEL_EN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [BUTTONS_WIDTH-1:0] inactive_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] inactive_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] inactive_out_down_levels,
  input  logic [BUTTONS_WIDTH-1:0] floor_enable,
  input  logic [FLOOR_BITS-1:0]    current_floor,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic                     any_active,
  output logic                     req_above,
  output logic                     req_here,
  output logic                     req_below
);

  localparam int W  = BUTTONS_WIDTH;
  localparam int N  = 3 * BUTTONS_WIDTH;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  // Channel k = g*W + i: group g (0 cabin, 1 hall-up, 2 hall-down), floor i.
  logic [N-1:0]  raw_all;
  logic [N-1:0]  clr_all;
  logic [N-1:0]  sync_a;
  logic [N-1:0]  sync_b;
  logic [N-1:0]  db;
  logic [N-1:0]  db_next;
  logic [N-1:0]  press;
  logic [N-1:0]  act;
  logic [N-1:0]  act_next;
  logic [CW-1:0] cnt      [N];
  logic [CW-1:0] cnt_next [N];
  logic [W-1:0]  req_any;
  logic          above_c;
  logic          here_c;
  logic          below_c;

  assign raw_all = {btn_down_out, btn_up_out, btn_in};
  assign clr_all = {inactive_out_down_levels, inactive_out_up_levels, inactive_in_levels};

  // A level change is accepted on the edge after the counter has seen it for DEBOUNCE_CYCLES edges.
  always_comb begin
    db_next = db;
    press   = '0;
    for (int k = 0; k < N; k++) begin
      cnt_next[k] = '0;
      if (sync_b[k] != db[k]) begin
        if (cnt[k] == CNT_MAX) begin
          db_next[k] = sync_b[k];
          press[k]   = sync_b[k];
        end else begin
          cnt_next[k] = cnt[k] + CW'(1);
        end
      end
    end
  end

  // A press outranks a clear strobe; on an active cabin bit it becomes a cancel.
  always_comb begin
    act_next = act;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < W; i++) begin
        if (!floor_enable[i]) begin
          act_next[g*W+i] = 1'b0;
        end else if ((g == 1 && i == W-1) || (g == 2 && i == 0)) begin
          act_next[g*W+i] = 1'b0;
        end else if (press[g*W+i]) begin
          act_next[g*W+i] = (g == 0 && CANCEL_EN) ? ~act[g*W+i] : 1'b1;
        end else if (clr_all[g*W+i]) begin
          act_next[g*W+i] = 1'b0;
        end
      end
    end
  end

  // An out-of-range floor puts every request below the car.
  always_comb begin
    req_any = act[W-1:0] | act[2*W-1:W] | act[N-1:2*W];
    above_c = 1'b0;
    here_c  = 1'b0;
    below_c = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (j > int'(current_floor)) begin
        above_c = above_c | req_any[j];
      end else if (j == int'(current_floor)) begin
        here_c = here_c | req_any[j];
      end else begin
        below_c = below_c | req_any[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a     <= '0;
      sync_b     <= '0;
      db         <= '0;
      act        <= '0;
      any_active <= 1'b0;
      req_above  <= 1'b0;
      req_here   <= 1'b0;
      req_below  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      sync_a     <= raw_all;
      sync_b     <= sync_a;
      db         <= db_next;
      act        <= act_next;
      any_active <= |req_any;
      req_above  <= above_c;
      req_here   <= here_c;
      req_below  <= below_c;
      for (int k = 0; k < N; k++) begin
        cnt[k] <= cnt_next[k];
      end
    end
  end

  assign active_in_levels       = act[W-1:0];
  assign active_out_up_levels   = act[2*W-1:W];
  assign active_out_down_levels = act[N-1:2*W];

endmodule

// File: tb/tb_request_latch_db.sv
// Directed bench for request_latch_db: one instance with cabin cancel, one without, driven in parallel.
module tb_request_latch_db;

  localparam int S_IN  = 0;
  localparam int S_UP  = 1;
  localparam int S_DN  = 2;
  localparam int S_SUM = 3;
  localparam int S_IN2 = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_in, btn_up_out, btn_down_out;
  logic [7:0] inactive_in_levels, inactive_out_up_levels, inactive_out_down_levels;
  logic [7:0] floor_enable;
  logic [2:0] current_floor;

  logic [7:0] a_in, a_up, a_dn;
  logic       a_any, a_above, a_here, a_below;
  logic [7:0] b_in, b_up, b_dn;
  logic       b_any, b_above, b_here, b_below;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  request_latch_db #(.BUTTONS_WIDTH(8), .FLOOR_BITS(3), .DEBOUNCE_CYCLES(4), .CANCEL_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .btn_in(btn_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .inactive_in_levels(inactive_in_levels), .inactive_out_up_levels(inactive_out_up_levels),
    .inactive_out_down_levels(inactive_out_down_levels),
    .floor_enable(floor_enable), .current_floor(current_floor),
    .active_in_levels(a_in), .active_out_up_levels(a_up), .active_out_down_levels(a_dn),
    .any_active(a_any), .req_above(a_above), .req_here(a_here), .req_below(a_below)
  );

  request_latch_db #(.BUTTONS_WIDTH(8), .FLOOR_BITS(3), .DEBOUNCE_CYCLES(4), .CANCEL_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset),
    .btn_in(btn_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .inactive_in_levels(inactive_in_levels), .inactive_out_up_levels(inactive_out_up_levels),
    .inactive_out_down_levels(inactive_out_down_levels),
    .floor_enable(floor_enable), .current_floor(current_floor),
    .active_in_levels(b_in), .active_out_up_levels(b_up), .active_out_down_levels(b_dn),
    .any_active(b_any), .req_above(b_above), .req_here(b_here), .req_below(b_below)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      S_IN:    return a_in;
      S_UP:    return a_up;
      S_DN:    return a_dn;
      S_SUM:   return {4'h0, a_any, a_above, a_here, a_below};
      default: return b_in;
    endcase
  endfunction

  // Summary encoding: {any_active, req_above, req_here, req_below}.
  task automatic exp_at(input int d, input int sel, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int q = sb.size() - 1; q >= 0; q--) begin
      if (sb[q].cyc == cyc) begin
        n_vec++;
        if (actual(sb[q].sel) !== sb[q].val) begin
          n_miss++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", sb[q].name, cyc, actual(sb[q].sel), sb[q].val);
        end
        sb.delete(q);
      end
    end
  end

  initial begin
    #100000;
    n_miss++;
    $display("FAIL watchdog: timed out at cyc %0d, expected scenario end", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    reset = 1'b1;
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    inactive_in_levels = '0; inactive_out_up_levels = '0; inactive_out_down_levels = '0;
    floor_enable = 8'hFF;
    current_floor = 3'd2;
    tick(3);
    n_vec++;
    if (a_in !== 8'h00) begin
      n_miss++;
      $display("FAIL init_rst_in: got %h, expected 00", a_in);
    end
    n_vec++;
    if (b_in !== 8'h00) begin
      n_miss++;
      $display("FAIL init_rst_in_nc: got %h, expected 00", b_in);
    end
    n_vec++;
    if ({a_any, a_above, a_here, a_below} !== 4'h0) begin
      n_miss++;
      $display("FAIL init_rst_sum: got %b, expected 0000", {a_any, a_above, a_here, a_below});
    end
    exp_at(1, S_IN, 8'h00, "rst_in");
    exp_at(1, S_UP, 8'h00, "rst_up");
    exp_at(1, S_DN, 8'h00, "rst_dn");
    exp_at(1, S_SUM, 8'h00, "rst_sum");
    tick(1);
    reset = 1'b0;
    tick(2);

    // basic latch and latency on cabin floor 5
    btn_in[5] = 1'b1;
    exp_at(6, S_IN, 8'h00, "basic_early");
    exp_at(7, S_IN, 8'h20, "basic_set");
    exp_at(7, S_IN2, 8'h20, "basic_set_nc");
    exp_at(7, S_SUM, 8'h00, "basic_sum_lag");
    exp_at(8, S_SUM, 8'h0C, "basic_sum_above");
    tick(10);
    btn_in[5] = 1'b0;
    tick(10);
    current_floor = 3'd5;
    exp_at(1, S_SUM, 8'h0A, "sum_here");
    tick(1);
    current_floor = 3'd7;
    exp_at(1, S_SUM, 8'h09, "sum_below");
    tick(1);
    current_floor = 3'd0;
    exp_at(1, S_SUM, 8'h0C, "sum_above_f0");
    tick(1);
    current_floor = 3'd2;
    inactive_in_levels[5] = 1'b1;
    exp_at(1, S_IN, 8'h00, "strobe_clear");
    exp_at(1, S_IN2, 8'h00, "strobe_clear_nc");
    exp_at(2, S_SUM, 8'h00, "sum_idle");
    tick(1);
    inactive_in_levels = '0;
    tick(3);

    // bounce on hall-up floor 3, then stable high
    for (int p = 0; p < 5; p++) begin
      btn_up_out[3] = 1'b1;
      exp_at(2, S_UP, 8'h00, "bounce_hold_off");
      tick(2);
      btn_up_out[3] = 1'b0;
      tick(2);
    end
    btn_up_out[3] = 1'b1;
    exp_at(6, S_UP, 8'h00, "bounce_early");
    exp_at(7, S_UP, 8'h08, "bounce_set");
    tick(8);
    btn_up_out[3] = 1'b0;
    tick(8);
    inactive_out_up_levels[3] = 1'b1;
    exp_at(1, S_UP, 8'h00, "up_clear");
    tick(1);
    inactive_out_up_levels = '0;
    tick(2);

    // press vs clear strobe on hall-down floor 4
    btn_down_out[4] = 1'b1;
    exp_at(7, S_DN, 8'h10, "dn_set");
    tick(8);
    btn_down_out[4] = 1'b0;
    tick(8);
    btn_down_out[4] = 1'b1;
    exp_at(6, S_DN, 8'h10, "dn_still_set");
    exp_at(7, S_DN, 8'h10, "collision_press_wins");
    exp_at(8, S_DN, 8'h00, "lone_strobe_clear");
    tick(6);
    inactive_out_down_levels[4] = 1'b1;
    tick(2);
    inactive_out_down_levels = '0;
    tick(1);
    btn_down_out[4] = 1'b0;
    tick(8);

    // cabin cancel: instance with cancel toggles, the other stays set; a long hold is one press
    btn_in[2] = 1'b1;
    exp_at(7, S_IN, 8'h04, "cancel_first_set");
    exp_at(7, S_IN2, 8'h04, "nocancel_first_set");
    exp_at(14, S_IN, 8'h04, "hold_one_press");
    tick(15);
    btn_in[2] = 1'b0;
    tick(8);
    btn_in[2] = 1'b1;
    exp_at(7, S_IN, 8'h00, "cancel_cleared");
    exp_at(7, S_IN2, 8'h04, "nocancel_stays");
    tick(8);
    btn_in[2] = 1'b0;
    tick(8);
    inactive_in_levels[2] = 1'b1;
    exp_at(1, S_IN2, 8'h00, "nocancel_strobe_clear");
    tick(1);
    inactive_in_levels = '0;
    tick(2);

    // floor mask and nonexistent hall buttons
    btn_in[6] = 1'b1;
    exp_at(7, S_IN, 8'h40, "mask_pre_set");
    tick(8);
    btn_in[6] = 1'b0;
    tick(8);
    floor_enable[6] = 1'b0;
    exp_at(1, S_IN, 8'h00, "mask_clears");
    tick(2);
    btn_in[6] = 1'b1;
    exp_at(7, S_IN, 8'h00, "mask_ignores_press");
    exp_at(7, S_IN2, 8'h00, "mask_ignores_press_nc");
    tick(8);
    btn_in[6] = 1'b0;
    tick(8);
    floor_enable = 8'hFF;
    btn_up_out[7] = 1'b1;
    btn_up_out[6] = 1'b1;
    btn_down_out[0] = 1'b1;
    exp_at(7, S_UP, 8'h40, "no_up_top");
    exp_at(7, S_DN, 8'h00, "no_down_bottom");
    tick(8);
    btn_up_out = '0;
    btn_down_out = '0;
    tick(8);
    inactive_out_up_levels[6] = 1'b1;
    exp_at(1, S_UP, 8'h00, "up6_clear");
    tick(1);
    inactive_out_up_levels = '0;
    tick(2);

    // reset mid-debounce with a request latched, cabin 1 held through release
    btn_up_out[1] = 1'b1;
    exp_at(7, S_UP, 8'h02, "pre_reset_set");
    exp_at(8, S_SUM, 8'h09, "pre_reset_sum");
    tick(8);
    btn_up_out[1] = 1'b0;
    btn_in[1] = 1'b1;
    tick(3);
    reset = 1'b1;
    exp_at(1, S_IN, 8'h00, "mid_rst_in");
    exp_at(1, S_UP, 8'h00, "mid_rst_up");
    exp_at(1, S_SUM, 8'h00, "mid_rst_sum");
    tick(2);
    reset = 1'b0;
    exp_at(6, S_IN, 8'h00, "post_rst_early");
    exp_at(7, S_IN, 8'h02, "post_rst_set");
    exp_at(7, S_IN2, 8'h02, "post_rst_set_nc");
    exp_at(8, S_SUM, 8'h09, "post_rst_sum");
    tick(10);
    n_vec++;
    if (a_in !== 8'h02) begin
      n_miss++;
      $display("FAIL post_rst_hold_in: got %h, expected 02", a_in);
    end
    n_vec++;
    if (b_in !== 8'h02) begin
      n_miss++;
      $display("FAIL post_rst_hold_in_nc: got %h, expected 02", b_in);
    end
    n_vec++;
    if (a_up !== 8'h00) begin
      n_miss++;
      $display("FAIL post_rst_up: got %h, expected 00", a_up);
    end
    n_vec++;
    if ({a_any, a_above, a_here, a_below} !== 4'b1001) begin
      n_miss++;
      $display("FAIL post_rst_hold_sum: got %b, expected 1001", {a_any, a_above, a_here, a_below});
    end
    btn_in[1] = 1'b0;
    tick(3);

    while (sb.size() > 0) begin
      n_miss++;
      $display("FAIL %s: never checked, expected %h at cyc %0d", sb[0].name, sb[0].val, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
